arb2to1_rr: RTL and testbench

- Two-input round-robin packet arbiter with a registered output stage.
- Sits directly upstream of the 2:1 selection stage. It decides which of two valid/ready sources, A or B, owns the shared output.
- Holds ownership for a whole packet (until a beat with last=1).
- Presents the chosen beat, its last flag and the select index (0=A, 1=B, the same polarity as the 2:1 selector) one cycle later.

---
 rtl/arb_pkg.sv | 13 +
 rtl/out_reg_stage.sv | 45 ++++
 rtl/arb2to1_rr.sv | 113 +++++++++++
 tb/tb_arb2to1_rr.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and source indices for the 2:1 round-robin arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/out_reg_stage.sv
// rtl/out_reg_stage.sv - one-entry output register holding beat data, last flag, source index and valid
module out_reg_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         sel_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         sel_o
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         last_q;
  logic         sel_q;

  // A drain without a load only clears valid; payload keeps its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
      sel_q   <= sel_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign sel_o   = sel_q;

endmodule

// File: rtl/arb2to1_rr.sv
// rtl/arb2to1_rr.sv - two-source round-robin packet arbiter with a registered output beat
module arb2to1_rr
  import arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  output logic         y_last,
  output logic         y_sel,
  input  logic         y_ready
);

  state_e       state_q;
  logic         last_served_q;
  logic         load_ok;
  logic         gnt_a;
  logic         gnt_b;
  logic         acc_a;
  logic         acc_b;
  logic         load;
  logic [W-1:0] mux_data;
  logic         mux_last;
  logic         mux_sel;

  assign load_ok = !y_valid || y_ready;

  // A locked source keeps the grant even while its valid is low.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      LOCK_A: gnt_a = 1'b1;
      LOCK_B: gnt_b = 1'b1;
      default: begin
        if (a_valid && (!b_valid || last_served_q == SRC_B)) begin
          gnt_a = 1'b1;
        end else if (b_valid) begin
          gnt_b = 1'b1;
        end
      end
    endcase
  end

  assign a_ready = rst_n && gnt_a && load_ok;
  assign b_ready = rst_n && gnt_b && load_ok;
  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;
  assign load    = acc_a || acc_b;

  assign mux_sel  = acc_b ? SRC_B : SRC_A;
  assign mux_data = acc_b ? b_data : a_data;
  assign mux_last = acc_b ? b_last : a_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= SRC_B;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_a) begin
            if (a_last) last_served_q <= SRC_A;
            else        state_q       <= LOCK_A;
          end else if (acc_b) begin
            if (b_last) last_served_q <= SRC_B;
            else        state_q       <= LOCK_B;
          end
        end
        LOCK_A: begin
          if (acc_a && a_last) begin
            state_q       <= IDLE;
            last_served_q <= SRC_A;
          end
        end
        LOCK_B: begin
          if (acc_b && b_last) begin
            state_q       <= IDLE;
            last_served_q <= SRC_B;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  out_reg_stage #(
    .W (W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .drain_i (y_ready),
    .data_i  (mux_data),
    .last_i  (mux_last),
    .sel_i   (mux_sel),
    .valid_o (y_valid),
    .data_o  (y_data),
    .last_o  (y_last),
    .sel_o   (y_sel)
  );

endmodule

// File: tb/tb_arb2to1_rr.sv
// tb/tb_arb2to1_rr.sv - directed and randomized checks of the 2:1 round-robin packet arbiter
module tb_arb2to1_rr;
  import arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       y_valid, y_last, y_sel, y_ready;
  logic [7:0] y_data;

  int checks = 0;
  int errors = 0;

  arb2to1_rr #(.W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_sel   (y_sel),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; y_ready = 1'b0;
    a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
    clk_step; clk_step; settle;
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
    checks++; if (y_data !== 8'h00) begin errors++; $display("FAIL reset_y_data: got %h want 00", y_data); end
    checks++; if (y_last !== 1'b0) begin errors++; $display("FAIL reset_y_last: got %b want 0", y_last); end
    checks++; if (y_sel !== 1'b0) begin errors++; $display("FAIL reset_y_sel: got %b want 0", y_sel); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    a_valid = 1'b1; y_ready = 1'b1; settle;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready_held: got %b want 0", a_ready); end
    a_valid = 1'b0; y_ready = 1'b0;
  endtask

  task automatic test_tie;
    rst_n = 1'b1; y_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
    settle;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL tie_first_grant: got a=%b b=%b want 1 0", a_ready, b_ready); end
    clk_step;
    checks++; if (y_valid !== 1'b1 || y_data !== 8'h11 || y_sel !== 1'b0 || y_last !== 1'b1) begin errors++; $display("FAIL tie_beat_a: got v=%b d=%h s=%b l=%b want 1 11 0 1", y_valid, y_data, y_sel, y_last); end
    a_valid = 1'b0; settle;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL tie_b_ready: got %b want 1", b_ready); end
    clk_step;
    checks++; if (y_valid !== 1'b1 || y_data !== 8'h22 || y_sel !== 1'b1) begin errors++; $display("FAIL tie_beat_b: got v=%b d=%h s=%b want 1 22 1", y_valid, y_data, y_sel); end
    b_valid = 1'b0; clk_step;
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL tie_drain: got y_valid=%b want 0", y_valid); end
  endtask

  task automatic test_lock;
    logic [7:0] ad [3];
    ad[0] = 8'h01; ad[1] = 8'h02; ad[2] = 8'h03;
    b_valid = 1'b1; b_data = 8'hAA; b_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_data = ad[i]; a_last = (i == 2);
      settle;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL lock_ready_%0d: got a=%b b=%b want 1 0", i, a_ready, b_ready); end
      clk_step;
      checks++; if (y_valid !== 1'b1 || y_data !== ad[i] || y_sel !== 1'b0 || y_last !== (i == 2)) begin errors++; $display("FAIL lock_beat_%0d: got v=%b d=%h s=%b l=%b want 1 %h 0 %b", i, y_valid, y_data, y_sel, y_last, ad[i], (i == 2)); end
    end
    a_valid = 1'b0; settle;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL lock_release_b_ready: got %b want 1", b_ready); end
    clk_step;
    checks++; if (y_data !== 8'hAA || y_sel !== 1'b1) begin errors++; $display("FAIL lock_beat_b: got d=%h s=%b want AA 1", y_data, y_sel); end
    b_valid = 1'b0; clk_step;
  endtask

  task automatic test_backpressure;
    a_valid = 1'b1; a_data = 8'h55; a_last = 1'b1; y_ready = 1'b1;
    clk_step;
    checks++; if (y_valid !== 1'b1 || y_data !== 8'h55) begin errors++; $display("FAIL bp_load: got v=%b d=%h want 1 55", y_valid, y_data); end
    a_data = 8'h66; y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready_%0d: got %b want 0", i, a_ready); end
      clk_step;
      checks++; if (y_valid !== 1'b1 || y_data !== 8'h55) begin errors++; $display("FAIL bp_hold_%0d: got v=%b d=%h want 1 55", i, y_valid, y_data); end
    end
    y_ready = 1'b1; settle;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: got %b want 1", a_ready); end
    clk_step;
    checks++; if (y_valid !== 1'b1 || y_data !== 8'h66) begin errors++; $display("FAIL bp_next_beat: got v=%b d=%h want 1 66", y_valid, y_data); end
    a_valid = 1'b0; clk_step;
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got y_valid=%b want 0", y_valid); end
  endtask

  task automatic test_gap;
    a_valid = 1'b1; a_data = 8'h10; a_last = 1'b0; b_valid = 1'b0;
    clk_step;
    checks++; if (y_data !== 8'h10 || y_sel !== 1'b0 || y_last !== 1'b0) begin errors++; $display("FAIL gap_first: got d=%h s=%b l=%b want 10 0 0", y_data, y_sel, y_last); end
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL gap_b_blocked_%0d: got %b want 0", i, b_ready); end
      clk_step;
    end
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1; settle;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL gap_resume: got a=%b b=%b want 1 0", a_ready, b_ready); end
    clk_step;
    checks++; if (y_valid !== 1'b1 || y_data !== 8'h11 || y_sel !== 1'b0) begin errors++; $display("FAIL gap_last: got v=%b d=%h s=%b want 1 11 0", y_valid, y_data, y_sel); end
    a_valid = 1'b0; settle;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL gap_b_granted: got %b want 1", b_ready); end
    clk_step;
    checks++; if (y_data !== 8'hBB || y_sel !== 1'b1) begin errors++; $display("FAIL gap_beat_b: got d=%h s=%b want BB 1", y_data, y_sel); end
    b_valid = 1'b0; clk_step;
  endtask

  task automatic test_reset_mid;
    b_valid = 1'b1; b_data = 8'hC1; b_last = 1'b0; a_valid = 1'b0;
    clk_step;
    checks++; if (y_valid !== 1'b1 || y_sel !== 1'b1 || dut.state_q !== LOCK_B) begin errors++; $display("FAIL rmid_locked: got v=%b s=%b st=%0d want 1 1 LOCK_B", y_valid, y_sel, dut.state_q); end
    rst_n = 1'b0; b_data = 8'hC2; settle;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rmid_b_ready: got %b want 0", b_ready); end
    clk_step;
    checks++; if (y_valid !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_cleared: got v=%b st=%0d want 0 IDLE", y_valid, dut.state_q); end
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'hE1; a_last = 1'b1;
    b_data = 8'hE2; b_last = 1'b1; settle;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL rmid_tie: got a=%b b=%b want 1 0", a_ready, b_ready); end
    clk_step;
    checks++; if (y_data !== 8'hE1 || y_sel !== 1'b0) begin errors++; $display("FAIL rmid_beat_a: got d=%h s=%b want E1 0", y_data, y_sel); end
    a_valid = 1'b0; clk_step;
    checks++; if (y_data !== 8'hE2 || y_sel !== 1'b1) begin errors++; $display("FAIL rmid_beat_b: got d=%h s=%b want E2 1", y_data, y_sel); end
    b_valid = 1'b0; clk_step;
  endtask

  // Packet-level reference: each source's beats must emerge in order, whole packets
  // are never interleaved, and the grant follows owner / favoured-source rules.
  task automatic test_random;
    logic [8:0] aq[$], bq[$], asb[$], bsb[$];
    logic [8:0] beat, want;
    int         owner;   // 0 none, 1 A owns packet, 2 B owns packet
    int         favour;  // source that wins the next tie: 0 A, 1 B
    int         cur;     // source of the packet currently streaming out, -1 none
    int         cycles, len;
    logic       m_yv, lo, ea, eb, ma, mb, acc_a, acc_b;
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) aq.push_back({(i == len - 1), 8'($urandom)});
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) bq.push_back({(i == len - 1), 8'($urandom)});
    end
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    clk_step;
    rst_n = 1'b1;
    owner = 0; favour = 0; cur = -1; m_yv = 1'b0; cycles = 0;
    while ((aq.size() + bq.size() + asb.size() + bsb.size()) != 0 && cycles < 4000) begin
      if (!a_valid && aq.size() > 0 && $urandom_range(0, 3) != 0) begin
        beat = aq.pop_front(); a_valid = 1'b1; a_data = beat[7:0]; a_last = beat[8]; asb.push_back(beat);
      end
      if (!b_valid && bq.size() > 0 && $urandom_range(0, 3) != 0) begin
        beat = bq.pop_front(); b_valid = 1'b1; b_data = beat[7:0]; b_last = beat[8]; bsb.push_back(beat);
      end
      y_ready = ($urandom_range(0, 9) < 7);
      settle;
      lo = !m_yv || y_ready;
      ea = 1'b0; eb = 1'b0;
      if (owner == 1) ea = lo;
      else if (owner == 2) eb = lo;
      else if (a_valid && (!b_valid || favour == 0)) ea = lo;
      else if (b_valid) eb = lo;
      checks++; if (a_ready !== ea || b_ready !== eb) begin errors++; $display("FAIL rnd_ready cyc %0d: got a=%b b=%b want %b %b", cycles, a_ready, b_ready, ea, eb); end
      checks++; if (y_valid !== m_yv) begin errors++; $display("FAIL rnd_y_valid cyc %0d: got %b want %b", cycles, y_valid, m_yv); end
      if (y_valid && y_ready) begin
        if ((y_sel ? bsb.size() : asb.size()) == 0) begin
          checks++; errors++; $display("FAIL rnd_unexpected cyc %0d: got sel=%b d=%h want no beat", cycles, y_sel, y_data);
        end else begin
          want = y_sel ? bsb.pop_front() : asb.pop_front();
          checks++; if ({y_last, y_data} !== want) begin errors++; $display("FAIL rnd_beat cyc %0d: got l=%b d=%h want l=%b d=%h", cycles, y_last, y_data, want[8], want[7:0]); end
        end
        if (cur != -1) begin
          checks++; if (int'(y_sel) != cur) begin errors++; $display("FAIL rnd_interleave cyc %0d: got sel=%b want %0d", cycles, y_sel, cur); end
        end
        cur = y_last ? -1 : int'(y_sel);
      end
      ma = a_valid && ea;
      mb = b_valid && eb;
      if (ma) begin
        if (a_last) begin owner = 0; favour = 1; end else owner = 1;
        want = {a_last, a_data};
      end else if (mb) begin
        if (b_last) begin owner = 0; favour = 0; end else owner = 2;
        want = {b_last, b_data};
      end
      if (ma || mb) m_yv = 1'b1;
      else if (y_ready) m_yv = 1'b0;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      clk_step;
      if (ma || mb) begin
        checks++; if (y_sel !== mb || {y_last, y_data} !== want) begin errors++; $display("FAIL rnd_load cyc %0d: got s=%b l=%b d=%h want %b %b %h", cycles, y_sel, y_last, y_data, mb, want[8], want[7:0]); end
      end
      if (acc_a) a_valid = 1'b0;
      if (acc_b) b_valid = 1'b0;
      cycles++;
    end
    checks++; if ((aq.size() + bq.size() + asb.size() + bsb.size()) != 0) begin errors++; $display("FAIL rnd_timeout: got %0d beats outstanding want 0", aq.size() + bq.size() + asb.size() + bsb.size()); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_tie;
    test_lock;
    test_backpressure;
    test_gap;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
